// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit:
// op encodings, sequencing states and the default datapath width.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Execute/decode-facing bundle of the multiply/divide unit.
// master = pipeline side, slave = the sequencer.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             hilo_rd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             stall;

    modport master (
        output start, op, rs_val, rt_val, flush,
        output mthi, mtlo, wdata, hilo_rd,
        input  hi, lo, busy, done, div_zero, stall
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        input  mthi, mtlo, wdata, hilo_rd,
        output hi, lo, busy, done, div_zero, stall
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step
// or restoring-divide step on the {acc_hi, acc_lo} accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : '0);
        sh   = {acc_hi, acc_lo[WIDTH-1]};
        ge   = (sh >= {1'b0, b});
        // remainder after a successful subtract is < b, so W bits suffice
        diff = sh[WIDTH-1:0] - b;
        if (is_div) begin
            nxt_hi = ge ? diff : sh[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers,
// with MTHI/MTLO writes and the decode-stage stall request.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, nstate;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, bm;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_q;

    logic             launch;
    logic             is_div, is_sgn;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] q_s, r_s;
    logic             dz;

    assign launch = bus.start & ~bus.flush;
    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .b      (bm),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    always_comb begin
        abs_a  = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b  = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
        prod   = {acc_hi, acc_lo};
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -acc_lo : acc_lo;
        r_s    = neg_r ? -acc_hi : acc_hi;
        dz     = is_div && (b_q == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE: if (launch) nstate = S_PREP;
            S_PREP: nstate = bus.flush ? S_IDLE : S_RUN;
            S_RUN: begin
                if (bus.flush)      nstate = S_IDLE;
                else if (cnt == '0) nstate = S_FIX;
            end
            S_FIX:   nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            bm     <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        op_q <= bus.op;
                        a_q  <= bus.rs_val;
                        b_q  <= bus.rt_val;
                        dz_q <= 1'b0;
                    end
                    if (!bus.start && bus.mthi) hi_q <= bus.wdata;
                    if (!bus.start && bus.mtlo) lo_q <= bus.wdata;
                end
                S_PREP: begin
                    acc_hi <= '0;
                    acc_lo <= is_div ? abs_a : abs_b;
                    bm     <= is_div ? abs_b : abs_a;
                    cnt    <= CW'(WIDTH - 1);
                    neg_q  <= is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r  <= is_sgn & a_q[WIDTH-1];
                end
                S_RUN: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        dz_q   <= dz;
                        // divide by zero bypasses the loop result entirely
                        if (dz) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else if (is_div) begin
                            hi_q <= r_s;
                            lo_q <= q_s;
                        end else begin
                            hi_q <= prod_s[2*WIDTH-1:WIDTH];
                            lo_q <= prod_s[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.stall    = bus.hilo_rd & (bus.busy | bus.start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: fixed vectors, corner sequences and
// random operations checked against a plain-arithmetic model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] rs, rt,
                                  output logic [31:0] hi, lo,
                                  output logic dz);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'b0, rs};
        ub = {32'b0, rt};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                p = sa * sb;
                {hi, lo} = p;
            end
            OP_MULTU: begin
                up = ua * ub;
                {hi, lo} = up;
            end
            default: begin
                if (rt == 0) begin
                    dz = 1'b1;
                    hi = rs;
                    lo = '1;
                end else if (op == OP_DIV) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = 32'(ua / ub);
                    hi = 32'(ua % ub);
                end
            end
        endcase
    endfunction

    // caller is at a negedge; returns at the negedge where done is seen
    task automatic do_op(input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, output int lat);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op     = 2'($urandom);
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t        tbl[9];
    int          lat;
    int          ndone;
    logic [31:0] ehi, elo;
    logic        edz;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        tbl[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1] = '{OP_MULT, 32'hFFFFFFFD, 32'd7,
                   32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2] = '{OP_DIV, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{OP_DIVU, 32'd100, 32'd0,
                   32'd100, 32'hFFFFFFFF, 1'b1};
        tbl[4] = '{OP_DIVU, 32'd100, 32'd7,
                   32'd2, 32'd14, 1'b0};
        tbl[5] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                   32'h0, 32'h80000000, 1'b0};
        tbl[6] = '{OP_DIV, 32'd7, 32'hFFFFFFFE,
                   32'd1, 32'hFFFFFFFD, 1'b0};
        tbl[7] = '{OP_MULT, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h0, 1'b0};
        tbl[8] = '{OP_DIV, 32'd5, 32'd0,
                   32'd5, 32'hFFFFFFFF, 1'b1};

        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        bus.flush   = 1'b0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wdata   = '0;
        bus.hilo_rd = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dz", bus.div_zero, 0);
        chk("rst_stall", bus.stall, 0);
        reset_n = 1'b1;

        @(negedge clk);
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].rs, tbl[i].rt, lat);
            chk($sformatf("v%0d_lat", i), lat, LAT);
            chk($sformatf("v%0d_busy", i), bus.busy, 0);
            chk($sformatf("v%0d_hi", i), bus.hi, tbl[i].hi);
            chk($sformatf("v%0d_lo", i), bus.lo, tbl[i].lo);
            chk($sformatf("v%0d_dz", i), bus.div_zero, tbl[i].dz);
            @(negedge clk);
            chk($sformatf("v%0d_done_once", i), bus.done, 0);
        end

        // MTHI/MTLO together in IDLE, then mthi ignored alongside start
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h11111111;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        chk("mt_hi", bus.hi, 32'h11111111);
        chk("mt_lo", bus.lo, 32'h11111111);
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h22222222;
        @(negedge clk);
        bus.mtlo  = 1'b0;
        chk("mtlo_only", bus.lo, 32'h22222222);
        chk("mtlo_hi_kept", bus.hi, 32'h11111111);
        bus.mthi  = 1'b1;
        bus.wdata = 32'h33333333;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd5;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.start = 1'b0;
        chk("mthi_vs_start", bus.hi, 32'h11111111);

        // flush at RUN cycle 10: no done, HI/LO untouched
        for (int k = 2; k <= 11; k++) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("flush_no_done", ndone, 0);
        chk("flush_hi", bus.hi, 32'h11111111);
        chk("flush_lo", bus.lo, 32'h22222222);

        // start together with flush in IDLE is dropped
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("start_flush_busy", bus.busy, 0);

        // stall held from the start cycle; mthi during RUN is ignored
        model(OP_MULT, 32'h12345678, 32'hFEDCBA98, ehi, elo, edz);
        bus.hilo_rd = 1'b1;
        bus.start   = 1'b1;
        bus.op      = OP_MULT;
        bus.rs_val  = 32'h12345678;
        bus.rt_val  = 32'hFEDCBA98;
        #1 chk("stall_start", bus.stall, 1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.mthi  = (k == 10);
            bus.wdata = 32'hDEADBEEF;
            #1 chk($sformatf("stall_k%0d", k), bus.stall, (k < LAT));
        end
        bus.hilo_rd = 1'b0;
        chk("stall_done", bus.done, 1);
        chk("stall_hi", bus.hi, ehi);
        chk("stall_lo", bus.lo, elo);

        // random operations back-to-back against the model
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin ra = $urandom_range(0, 200);
                         rb = $urandom_range(1, 15); end
                3: ra = ra | 32'h80000000;
                default: ;
            endcase
            model(rop, ra, rb, ehi, elo, edz);
            do_op(rop, ra, rb, lat);
            chk($sformatf("r%0d_lat", n), lat, LAT);
            chk($sformatf("r%0d_hi", n), bus.hi, ehi);
            chk($sformatf("r%0d_lo", n), bus.lo, elo);
            chk($sformatf("r%0d_dz", n), bus.div_zero, edz);
        end

        // reset pulse mid-RUN returns everything to zero
        do_op(OP_DIVU, 32'd9, 32'd0, lat);
        chk("pre_rst_dz", bus.div_zero, 1);
        bus.start  = 1'b1;
        bus.op     = OP_MULT;
        bus.rs_val = 32'd5;
        bus.rt_val = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_hi", bus.hi, 0);
        chk("mrst_lo", bus.lo, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_dz", bus.div_zero, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
